// File: rtl/dual_port_ram_arbiter_pkg.sv
// Shared definitions for the dual_port_ram arbiter: requester limit, id-width helper,
// idle-port constants and the response pipeline stage record.
// No ports; imported by dual_port_ram_arbiter and dpram_rr_picker.
package dual_port_ram_arbiter_pkg;

  // Upper bound on requesters; also bounds the owner id width held in the pipeline.
  localparam int DPRAM_ARB_MAX_REQ = 16;

  // Ceiling log2, minimum result 1 so a 2-requester build still has a 1-bit id.
  function automatic int dpram_arb_clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  localparam int DPRAM_ARB_ID_W_MAX = dpram_arb_clog2(DPRAM_ARB_MAX_REQ);

  // Values an ungranted RAM port drives; addr/data idle value is all-zero ('0).
  localparam logic DPRAM_ARB_IDLE_WE   = 1'b0;
  localparam logic DPRAM_ARB_IDLE_BITS = 1'b0;

  // Statistics counter widths (only used when DPRAM_ARB_STATS_EN is defined).
  localparam int DPRAM_ARB_GRANTS_W    = 32;
  localparam int DPRAM_ARB_CONFLICTS_W = 16;

  // One response stage per RAM port: is a read in flight, and who owns it.
  typedef struct packed {
    logic                          rd_pending;
    logic [DPRAM_ARB_ID_W_MAX-1:0] owner_id;
  } rsp_stage_t;

endpackage

// File: rtl/dual_port_ram_arbiter_rr_picker.sv
// dpram_rr_picker: combinational round-robin scan returning the first and second
// valid requesters found starting at rr_ptr, wrapping past NUM_REQ-1 back to 0.
// Ports: valid (request vector), rr_ptr (scan start) -> first_*/second_* (valid, one-hot, index).
module dpram_rr_picker
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IW      = dpram_arb_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic               first_vld,
  output logic [NUM_REQ-1:0] first_oh,
  output logic [IW-1:0]      first_idx,
  output logic               second_vld,
  output logic [NUM_REQ-1:0] second_oh,
  output logic [IW-1:0]      second_idx
);

  logic [IW:0] pos;

  always_comb begin
    first_vld  = 1'b0;
    first_oh   = '0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_oh  = '0;
    second_idx = '0;
    pos        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr + k is below 2*NUM_REQ, so one conditional subtract wraps it.
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_REQ)) begin
        pos = pos - (IW+1)'(NUM_REQ);
      end
      if (valid[pos[IW-1:0]]) begin
        if (!first_vld) begin
          first_vld               = 1'b1;
          first_idx               = pos[IW-1:0];
          first_oh[pos[IW-1:0]]   = 1'b1;
        end else if (!second_vld) begin
          second_vld              = 1'b1;
          second_idx              = pos[IW-1:0];
          second_oh[pos[IW-1:0]]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// dual_port_ram_arbiter: shares one dual_port_ram between NUM_REQ requesters, granting
// up to two per cycle (port1 = first in round-robin order, port2 = next non-conflicting).
// Ports: req_* (valid/we/addr/data in, ready out), rsp_valid/rsp_data (read data one cycle
// after grant), ram_* (to/from dual_port_ram). Optional macro DPRAM_ARB_STATS_EN adds
// saturating stat_grants / stat_conflicts counters.
module dual_port_ram_arbiter
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic                          ram_we1,
  output logic [ADDR_WIDTH-1:0]         ram_addr1,
  output logic [DATA_WIDTH-1:0]         ram_data1,
  output logic                          ram_we2,
  output logic [ADDR_WIDTH-1:0]         ram_addr2,
  output logic [DATA_WIDTH-1:0]         ram_data2,
  input  logic [DATA_WIDTH-1:0]         ram_out1,
  input  logic [DATA_WIDTH-1:0]         ram_out2
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [DPRAM_ARB_GRANTS_W-1:0]    stat_grants,
  output logic [DPRAM_ARB_CONFLICTS_W-1:0] stat_conflicts
`endif
);

  localparam int IW = dpram_arb_clog2(NUM_REQ);

  logic [IW-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]    valid_live;
  logic                  first_vld, second_vld;
  logic [NUM_REQ-1:0]    first_oh, second_oh;
  logic [IW-1:0]         first_idx, second_idx;
  logic                  a_we, b_we;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] a_data, b_data;
  logic                  conflict;
  logic                  grant2;
  rsp_stage_t            stage1, stage2;

  // Nothing is granted while reset is held, so the RAM sees idle ports and no
  // read can enter the response pipeline during reset.
  assign valid_live = req_valid & {NUM_REQ{~reset}};

  dpram_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid      (valid_live),
    .rr_ptr     (rr_ptr),
    .first_vld  (first_vld),
    .first_oh   (first_oh),
    .first_idx  (first_idx),
    .second_vld (second_vld),
    .second_oh  (second_oh),
    .second_idx (second_idx)
  );

  assign a_we   = req_we[first_idx];
  assign b_we   = req_we[second_idx];
  assign a_addr = req_addr[int'(first_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign b_addr = req_addr[int'(second_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign a_data = req_data[int'(first_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign b_data = req_data[int'(second_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Two accesses to one address where either writes would race inside the RAM;
  // the second requester waits and port2 stays idle (the scan does not go further).
  assign conflict = first_vld & second_vld & (a_addr == b_addr) & (a_we | b_we);
  assign grant2   = second_vld & ~conflict;

  assign req_ready = first_oh | (grant2 ? second_oh : '0);

  always_comb begin
    ram_we1   = DPRAM_ARB_IDLE_WE;
    ram_addr1 = {ADDR_WIDTH{DPRAM_ARB_IDLE_BITS}};
    ram_data1 = {DATA_WIDTH{DPRAM_ARB_IDLE_BITS}};
    ram_we2   = DPRAM_ARB_IDLE_WE;
    ram_addr2 = {ADDR_WIDTH{DPRAM_ARB_IDLE_BITS}};
    ram_data2 = {DATA_WIDTH{DPRAM_ARB_IDLE_BITS}};
    if (first_vld) begin
      ram_we1   = a_we;
      ram_addr1 = a_addr;
      ram_data1 = a_data;
    end
    if (grant2) begin
      ram_we2   = b_we;
      ram_addr2 = b_addr;
      ram_data2 = b_data;
    end
  end

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // Pointer moves one past the last requester granted this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant2) begin
      rr_ptr <= ptr_after(second_idx);
    end else if (first_vld) begin
      rr_ptr <= ptr_after(first_idx);
    end
  end

  // The RAM output register lines up with these stages, so ram_outN is the read
  // data for the stage's owner in the cycle the stage is pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1.rd_pending <= first_vld & ~a_we;
      stage1.owner_id   <= DPRAM_ARB_ID_W_MAX'(first_idx);
      stage2.rd_pending <= grant2 & ~b_we;
      stage2.owner_id   <= DPRAM_ARB_ID_W_MAX'(second_idx);
    end
  end

  // Owners of the two stages always differ, since a requester gets at most one
  // port per cycle; IW never exceeds the stored owner width.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (stage1.rd_pending) begin
      rsp_valid[stage1.owner_id[IW-1:0]] = 1'b1;
      rsp_data[int'(stage1.owner_id[IW-1:0])*DATA_WIDTH +: DATA_WIDTH] = ram_out1;
    end
    if (stage2.rd_pending) begin
      rsp_valid[stage2.owner_id[IW-1:0]] = 1'b1;
      rsp_data[int'(stage2.owner_id[IW-1:0])*DATA_WIDTH +: DATA_WIDTH] = ram_out2;
    end
  end

`ifdef DPRAM_ARB_STATS_EN
  logic [1:0]                       grants_now;
  logic [DPRAM_ARB_GRANTS_W:0]      grants_sum;
  logic [DPRAM_ARB_CONFLICTS_W:0]   conflicts_sum;

  assign grants_now    = {1'b0, first_vld} + {1'b0, grant2};
  assign grants_sum    = {1'b0, stat_grants} + (DPRAM_ARB_GRANTS_W+1)'(grants_now);
  assign conflicts_sum = {1'b0, stat_conflicts} + (DPRAM_ARB_CONFLICTS_W+1)'(conflict);

  // Carry-out of the widened sum means the counter would wrap: hold at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_grants    <= grants_sum[DPRAM_ARB_GRANTS_W] ? '1
                                                       : grants_sum[DPRAM_ARB_GRANTS_W-1:0];
      stat_conflicts <= conflicts_sum[DPRAM_ARB_CONFLICTS_W] ? '1
                                                             : conflicts_sum[DPRAM_ARB_CONFLICTS_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Testbench for dual_port_ram_arbiter: directed scenarios then randomized traffic,
// each cycle compared against a list-based round-robin model with a shadow memory.
// Optional macro DPRAM_ARB_STATS_EN enables the statistics checks.
module tb_dual_port_ram_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data, rsp_data;
  logic              ram_we1, ram_we2;
  logic [AW-1:0]     ram_addr1, ram_addr2;
  logic [DW-1:0]     ram_data1, ram_data2, ram_out1, ram_out2;
`ifdef DPRAM_ARB_STATS_EN
  logic [31:0]       stat_grants;
  logic [15:0]       stat_conflicts;
`endif

  always #5 clk = ~clk;

  dual_port_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_we1(ram_we1), .ram_addr1(ram_addr1), .ram_data1(ram_data1),
    .ram_we2(ram_we2), .ram_addr2(ram_addr2), .ram_data2(ram_data2),
    .ram_out1(ram_out1), .ram_out2(ram_out2)
`ifdef DPRAM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  // Behavioural dual_port_ram: registered outputs, writes land at the clock edge.
  logic          ram_clr;
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= '0;
      ram_out1 <= '0;
      ram_out2 <= '0;
    end else begin
      if (ram_we1) ram_mem[ram_addr1] <= ram_data1;
      if (ram_we2) ram_mem[ram_addr2] <= ram_data2;
      ram_out1 <= ram_mem[ram_addr1];
      ram_out2 <= ram_mem[ram_addr2];
    end
  end

  // Reference model state.
  int            checks = 0;
  int            errors = 0;
  int            m_ptr = 0;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  logic [N-1:0]  exp_rsp_v = '0;
  logic [N*DW-1:0] exp_rsp_d = '0;
  logic [N-1:0]  m_granted = '0;
  logic [N-1:0]  obs_ready, obs_rsp_v;
  logic [N*DW-1:0] obs_rsp_d;

  // Per-requester stimulus.
  logic          tx_v [N];
  logic          tx_we [N];
  logic [AW-1:0] tx_addr [N];
  logic [DW-1:0] tx_data [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = tx_v[i];
      req_we[i]               = tx_we[i];
      req_addr[i*AW +: AW]    = tx_addr[i];
      req_data[i*DW +: DW]    = tx_data[i];
    end
  endtask

  task automatic set_tx(input int i, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    tx_v[i] = v; tx_we[i] = we; tx_addr[i] = a; tx_data[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_tx(i, 1'b0, 1'b0, '0, '0);
  endtask

  // Compare the DUT for the current cycle against the model, then advance the model.
  task automatic check_cycle();
    int            order[$];
    int            a, b;
    logic [N-1:0]  e_ready;
    logic          e_we1, e_we2;
    logic [AW-1:0] e_a1, e_a2;
    logic [DW-1:0] e_d1, e_d2;
    logic [N-1:0]  nxt_v;
    logic [N*DW-1:0] nxt_d;
    e_ready = '0; e_we1 = 0; e_we2 = 0; e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
    nxt_v = '0; nxt_d = '0;
    if (reset) begin
      exp_rsp_v = '0;
      exp_rsp_d = '0;
    end
    obs_ready = req_ready; obs_rsp_v = rsp_valid; obs_rsp_d = rsp_data;
    check("rsp_valid", rsp_valid, exp_rsp_v);
    check("rsp_data", rsp_data, exp_rsp_d);
    if (reset) begin
      m_ptr = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      if (order.size() > 0) begin
        a = order[0];
        e_ready[a] = 1'b1;
        e_we1 = req_we[a]; e_a1 = req_addr[a*AW +: AW]; e_d1 = req_data[a*DW +: DW];
        m_ptr = (a + 1) % N;
        if (order.size() > 1) begin
          b = order[1];
          if (!(req_addr[b*AW +: AW] == e_a1 && (req_we[a] || req_we[b]))) begin
            e_ready[b] = 1'b1;
            e_we2 = req_we[b]; e_a2 = req_addr[b*AW +: AW]; e_d2 = req_data[b*DW +: DW];
            m_ptr = (b + 1) % N;
            if (!e_we2) begin nxt_v[b] = 1'b1; nxt_d[b*DW +: DW] = m_mem[e_a2]; end
          end
        end
        if (!e_we1) begin nxt_v[a] = 1'b1; nxt_d[a*DW +: DW] = m_mem[e_a1]; end
        if (e_we1) m_mem[e_a1] = e_d1;
        if (e_we2) m_mem[e_a2] = e_d2;
      end
    end
    check("req_ready", req_ready, e_ready);
    check("ram_port1", {ram_we1, ram_addr1, ram_data1}, {e_we1, e_a1, e_d1});
    check("ram_port2", {ram_we2, ram_addr2, ram_data2}, {e_we2, e_a2, e_d2});
    exp_rsp_v = nxt_v;
    exp_rsp_d = nxt_d;
    m_granted = e_ready;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef DPRAM_ARB_STATS_EN
  logic [31:0] g0;
  logic [15:0] c0;
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    // Reset with every requester asking: nothing may be granted.
    reset = 1'b1; ram_clr = 1'b1;
    for (int i = 0; i < N; i++) set_tx(i, 1'b1, 1'b0, AW'(i), '0);
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", req_ready, '0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_rsp_data", rsp_data, '0);
    reset = 1'b0; ram_clr = 1'b0;
    idle_all();
    step();

    // Write 0xA5 to addr 5, then read it back through req0.
    set_tx(0, 1, 1, 10'd5, 8'hA5); step();
    check("s1_write_ready", obs_ready, 4'b0001);
    set_tx(0, 1, 0, 10'd5, 8'h00); step();
    check("s1_read_ready", obs_ready, 4'b0001);
    idle_all(); step();
    check("s1_rsp_valid", obs_rsp_v, 4'b0001);
    check("s1_rsp_data", obs_rsp_d[7:0], 8'hA5);

    // rr_ptr is 1: req1 writes addr 9 while req2 reads addr 9.
`ifdef DPRAM_ARB_STATS_EN
    g0 = stat_grants; c0 = stat_conflicts;
`endif
    set_tx(1, 1, 1, 10'd9, 8'h3C); set_tx(2, 1, 0, 10'd9, 8'h00); step();
    check("s3_conflict_ready", obs_ready, 4'b0010);
    set_tx(1, 0, 0, '0, '0); step();
    check("s3_wait_ready", obs_ready, 4'b0100);
    idle_all(); step();
    check("s3_rsp_valid", obs_rsp_v, 4'b0100);
    check("s3_rsp_data", obs_rsp_d[23:16], 8'h3C);
`ifdef DPRAM_ARB_STATS_EN
    check("s6_grants_delta", stat_grants - g0, 32'd2);
    check("s6_conflicts_delta", stat_conflicts - c0, 16'd1);
`endif

    // Reset in the cycle after a read grant drops the read.
    set_tx(0, 1, 0, 10'd5, 8'h00); step();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_tx(i, 1'b1, 1'b0, AW'(i), '0);
    step();
    check("s4_rsp_valid_in_reset", obs_rsp_v, '0);
    check("s4_ready_in_reset", obs_ready, '0);
    reset = 1'b0; idle_all(); step();
    check("s4_no_late_rsp", obs_rsp_v, '0);

    // Only req3 with rr_ptr 0: wrap-around grants req3, pointer returns to 0.
    set_tx(3, 1, 0, 10'd2, 8'h00); step();
    check("s5_wrap_ready", obs_ready, 4'b1000);
    idle_all();

    // All four read distinct addresses for four cycles.
    for (int i = 0; i < N; i++) set_tx(i, 1, 0, AW'(10 + i), 8'h00);
    step(); check("s2_cycle0", obs_ready, 4'b0011);
    step(); check("s2_cycle1", obs_ready, 4'b1100);
    step(); check("s2_cycle2", obs_ready, 4'b0011);
    step(); check("s2_cycle3", obs_ready, 4'b1100);
    idle_all(); step();

    // Read and write to different addresses use both ports.
    set_tx(0, 1, 1, 10'd20, 8'h77); set_tx(1, 1, 0, 10'd21, 8'h00); step();
    check("rw_both_ports", obs_ready, 4'b0011);
    idle_all(); step();

`ifdef DPRAM_ARB_STATS_EN
    force dut.stat_grants = 32'hFFFF_FFFF;
    force dut.stat_conflicts = 16'hFFFF;
    #1;
    release dut.stat_grants;
    release dut.stat_conflicts;
    set_tx(0, 1, 0, 10'd30, 8'h00); set_tx(1, 1, 0, 10'd31, 8'h00); step();
    set_tx(0, 1, 1, 10'd40, 8'h11); set_tx(1, 1, 0, 10'd40, 8'h00); step();
    check("stat_grants_sat", stat_grants, 32'hFFFF_FFFF);
    check("stat_conflicts_sat", stat_conflicts, 16'hFFFF);
    idle_all(); step(); step();
`endif

    // Randomized traffic over a small address window so conflicts occur often.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!tx_v[i] || m_granted[i]) begin
          set_tx(i, ($urandom % 100) < 65, $urandom % 2, AW'($urandom % 6),
                 DW'($urandom));
        end
      end
      step();
    end
    idle_all(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
